// File: rtl/melody_player.sv
// melody_player: plays a fixed 16-entry do/re/mi song with pause, stop, loop and volume control
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   play, stop            single-cycle pulses: start/pause/resume, abort to idle
//   loop_en               level: wrap to entry 0 after entry 15
//   vol_up, vol_dn        single-cycle pulses adjusting the 3-bit volume level
//   do_o, re_o, mi_o      registered one-hot note select, all zero for silence
//   high_vol, low_vol     registered square-wave amplitude pair
//   busy, done, note_idx  playback status
module melody_player #(
    parameter int unsigned BEAT_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES  = 2500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play,
    input  logic        stop,
    input  logic        loop_en,
    input  logic        vol_up,
    input  logic        vol_dn,
    output logic        do_o,
    output logic        re_o,
    output logic        mi_o,
    output logic [15:0] high_vol,
    output logic [15:0] low_vol,
    output logic        busy,
    output logic        done,
    output logic [3:0]  note_idx
);
    typedef enum logic [2:0] {S_IDLE, S_NOTE, S_GAP, S_PAUSE, S_DONE} state_t;

    // entry = {note code, beats}; codes 0 rest, 1 do, 2 re, 3 mi
    function automatic logic [4:0] rom(input logic [3:0] i);
        case (i)
            4'd0:    rom = {2'd3, 3'd1};
            4'd1:    rom = {2'd2, 3'd1};
            4'd2:    rom = {2'd1, 3'd1};
            4'd3:    rom = {2'd2, 3'd1};
            4'd4:    rom = {2'd3, 3'd1};
            4'd5:    rom = {2'd3, 3'd1};
            4'd6:    rom = {2'd3, 3'd2};
            4'd7:    rom = {2'd2, 3'd1};
            4'd8:    rom = {2'd2, 3'd1};
            4'd9:    rom = {2'd2, 3'd2};
            4'd10:   rom = {2'd3, 3'd1};
            4'd11:   rom = {2'd3, 3'd1};
            4'd12:   rom = {2'd3, 3'd2};
            4'd13:   rom = {2'd0, 3'd1};
            4'd14:   rom = {2'd1, 3'd1};
            default: rom = {2'd1, 3'd4};
        endcase
    endfunction

    function automatic logic [31:0] dur(input logic [3:0] i);
        logic [4:0] e;
        e = rom(i);
        dur = 32'(e[2:0]) * 32'(BEAT_CYCLES);
    endfunction

    state_t      r_state, r_saved;
    logic [31:0] r_cnt;
    logic [2:0]  r_lvl;

    state_t      w_run_s, w_ns, w_nsv;
    logic [31:0] w_run_c, w_nc;
    logic [3:0]  w_run_i, w_ni;
    logic [4:0]  w_ent;
    logic [1:0]  w_code;
    logic [2:0]  w_lvl;
    logic [15:0] w_hv;
    logic        w_last;

    // w_run_* is where an unpaused NOTE/GAP cycle would lead; a pause
    // captures that target so the cycle taking the pause still counts
    always_comb begin
        w_last  = r_cnt <= 32'd1;
        w_run_s = r_state;
        w_run_c = r_cnt - 32'd1;
        w_run_i = note_idx;
        if (r_state == S_NOTE && w_last) begin
            w_run_s = S_GAP;
            w_run_c = 32'(GAP_CYCLES);
        end
        if (r_state == S_GAP && w_last) begin
            w_run_s = (note_idx != 4'd15 || loop_en) ? S_NOTE : S_DONE;
            w_run_i = (note_idx != 4'd15) ? note_idx + 4'd1 : (loop_en ? 4'd0 : note_idx);
            w_run_c = (note_idx != 4'd15 || loop_en) ? dur(w_run_i) : 32'd0;
        end
        w_ns  = r_state;
        w_nc  = r_cnt;
        w_ni  = note_idx;
        w_nsv = r_saved;
        if (stop && r_state != S_IDLE) begin
            w_ns = S_IDLE;
            w_nc = 32'd0;
            w_ni = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: if (play) begin
                    w_ns = S_NOTE;
                    w_nc = dur(4'd0);
                    w_ni = 4'd0;
                end
                S_NOTE, S_GAP: begin
                    w_ns  = play ? S_PAUSE : w_run_s;
                    w_nsv = play ? w_run_s : r_saved;
                    w_nc  = w_run_c;
                    w_ni  = w_run_i;
                end
                S_PAUSE: w_ns = play ? r_saved : S_PAUSE;
                default: begin
                    w_ns = S_IDLE;
                    w_ni = 4'd0;
                end
            endcase
        end
        w_ent  = rom(w_ni);
        w_code = w_ent[4:3];
        w_lvl  = (vol_up && !vol_dn && r_lvl != 3'd7) ? r_lvl + 3'd1 :
                 (vol_dn && !vol_up && r_lvl != 3'd0) ? r_lvl - 3'd1 : r_lvl;
        w_hv   = {1'b0, r_lvl, 12'h000};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_saved  <= S_IDLE;
            r_cnt    <= 32'd0;
            note_idx <= 4'd0;
            do_o     <= 1'b0;
            re_o     <= 1'b0;
            mi_o     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            r_lvl    <= 3'd3;
            high_vol <= 16'h3000;
            low_vol  <= 16'hD000;
        end else begin
            r_state  <= w_ns;
            r_saved  <= w_nsv;
            r_cnt    <= w_nc;
            note_idx <= w_ni;
            do_o     <= w_ns == S_NOTE && w_code == 2'd1;
            re_o     <= w_ns == S_NOTE && w_code == 2'd2;
            mi_o     <= w_ns == S_NOTE && w_code == 2'd3;
            busy     <= w_ns == S_NOTE || w_ns == S_GAP || w_ns == S_PAUSE;
            done     <= w_ns == S_DONE;
            r_lvl    <= w_lvl;
            high_vol <= w_hv;
            low_vol  <= -w_hv;
        end
    end
endmodule
